// File: rtl/adsr_vca.sv
// adsr_vca: VCA stage after the ADSR envelope. Per accepted sample strobe,
// multiplies a signed sample by the unsigned envelope with a bit-serial
// shift-add unit, then rounds half-up and saturates back to SW bits.
// Optional feature macro: VCA_SMOOTH_EN (one-pole envelope smoother).
module adsr_vca #(
    parameter int unsigned SW    = 16,
    parameter int unsigned EW    = 24,
    parameter int unsigned OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             low_strobe,
    input  logic [SW-1:0]    sample_in,
    input  logic [EW-1:0]    env_in,
    output logic [SW-1:0]    sample_out,
    output logic             out_valid,
    output logic             busy,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int unsigned AW = SW + EW;
    localparam int unsigned CW = $clog2(EW);
    localparam int unsigned QW = SW + 1;
    localparam logic [AW:0] RND_HALF = {{(SW + 1){1'b0}}, 1'b1, {(EW - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      sample_q, sample_d;
    logic [EW-1:0]      env_q, env_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      sample_out_q, sample_out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [OVR_W-1:0]   ovr_q, ovr_d;

    logic [EW-1:0]      env_eff;
    logic [AW-1:0]      addend;
    logic signed [AW:0] rnd_sum;
    logic signed [SW:0] rnd_q;
    logic [SW-1:0]      sat_val;

`ifdef VCA_SMOOTH_EN
    logic [EW-1:0]      env_s_q, env_s_d;
    logic signed [EW:0] env_diff;

    // One-pole smoother: env_s + ((env_in - env_s) >>> 4)
    always_comb begin
        env_diff = $signed({1'b0, env_in}) - $signed({1'b0, env_s_q});
        env_eff  = EW'($signed({1'b0, env_s_q}) + (env_diff >>> 4));
    end

    // Smoother state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) env_s_q <= '0;
        else     env_s_q <= env_s_d;
    end
`else
    // Envelope used directly
    always_comb begin
        env_eff = env_in;
    end
`endif

    // Datapath: shifted partial product, round-half-up and saturation
    always_comb begin
        addend  = {{EW{sample_q[SW-1]}}, sample_q} << cnt_q;
        rnd_sum = $signed({acc_q[AW-1], acc_q}) + $signed(RND_HALF);
        rnd_q   = QW'(rnd_sum >>> EW);
        if (rnd_q[SW] != rnd_q[SW-1])
            sat_val = rnd_q[SW] ? {1'b1, {(SW - 1){1'b0}}} : {1'b0, {(SW - 1){1'b1}}};
        else
            sat_val = rnd_q[SW-1:0];
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        env_d        = env_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        busy_d       = busy_q;
        ovr_d        = ovr_q;
`ifdef VCA_SMOOTH_EN
        env_s_d      = env_s_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (low_strobe) begin
                    sample_d = sample_in;
                    env_d    = env_eff;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_MUL;
`ifdef VCA_SMOOTH_EN
                    env_s_d  = env_eff;
`endif
                end
            end
            S_MUL: begin
                if (env_q[cnt_q]) acc_d = acc_q + addend;
                if (cnt_q == CW'(EW - 1)) state_d = S_DONE;
                else                      cnt_d   = cnt_q + CW'(1);
            end
            S_DONE: begin
                sample_out_d = sat_val;
                out_valid_d  = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes arriving while a multiply is in flight are dropped and counted
        if (low_strobe && (state_q != S_IDLE) && (ovr_q != {OVR_W{1'b1}}))
            ovr_d = ovr_q + OVR_W'(1);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sample_q     <= '0;
            env_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            env_q        <= env_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            ovr_q        <= ovr_d;
        end
    end

    assign sample_out  = sample_out_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_adsr_vca.sv
// Bench for adsr_vca: scoreboard of expected samples, one task per scenario.
// With VCA_SMOOTH_EN defined only the reset and smoother scenarios run.
module tb_adsr_vca;

    localparam int SW = 16;
    localparam int EW = 24;
    localparam int OVR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             low_strobe;
    logic [SW-1:0]    sample_in;
    logic [EW-1:0]    env_in;
    logic [SW-1:0]    sample_out;
    logic             out_valid;
    logic             busy;
    logic [OVR_W-1:0] overrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    int env_s_m = 0;

    adsr_vca #(.SW(SW), .EW(EW), .OVR_W(OVR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .low_strobe  (low_strobe),
        .sample_in   (sample_in),
        .env_in      (env_in),
        .sample_out  (sample_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #10 clk = ~clk;

    // Exact signed product, round half up, saturate
    function automatic logic [15:0] model(input logic [15:0] s, input logic [23:0] e);
        longint p, r;
        p = longint'($signed(s)) * longint'({40'd0, e});
        r = (p + 64'sd8388608) >>> 24;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // Accepted strobe: drive it and push the expected result
    task automatic send(input logic [15:0] s, input logic [23:0] e);
        logic [23:0] eff;
`ifdef VCA_SMOOTH_EN
        env_s_m = env_s_m + ((int'({8'd0, e}) - env_s_m) >>> 4);
        eff = 24'(env_s_m);
`else
        eff = e;
`endif
        exp_q.push_back(model(s, eff));
        @(negedge clk);
        sample_in  = s;
        env_in     = e;
        low_strobe = 1'b1;
        @(negedge clk);
        low_strobe = 1'b0;
    endtask

    // Strobe expected to be dropped
    task automatic pulse_drop(input logic [15:0] s, input logic [23:0] e);
        @(negedge clk);
        sample_in  = s;
        env_in     = e;
        low_strobe = 1'b1;
        @(negedge clk);
        low_strobe = 1'b0;
    endtask

    // Edges from the strobe edge to the out_valid edge; -1 on timeout
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        low_strobe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        env_s_m = 0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        low_strobe = 1'b0;
        sample_in = '0;
        env_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (sample_out !== 16'h0000) begin n_bad++; $display("FAIL reset_sample_out: got %h want 0000", sample_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overrun_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_overrun: got %h want 00", overrun_cnt); end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] exp;
        send(16'h4000, 24'h800000);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_high: got %b want 1", busy); end
        wait_valid(lat);
        n_cmp++; if (lat != EW + 1) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, EW + 1); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++; if (sample_out !== exp) begin n_bad++; $display("FAIL basic_value: got %h want %h", sample_out, exp); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_low: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b want 0", out_valid); end
        n_cmp++; if (sample_out !== 16'h2000) begin n_bad++; $display("FAIL basic_hold: got %h want 2000", sample_out); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_patterns();
        logic [15:0] s_tab [4] = '{16'h7FFF, 16'h8000, 16'hC000, 16'h1234};
        logic [23:0] e_tab [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'h400000, 24'h000000};
        logic [15:0] r_tab [4] = '{16'h7FFF, 16'h8000, 16'hF000, 16'h0000};
        int lat;
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) begin
            send(s_tab[i], e_tab[i]);
            wait_valid(lat);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_cmp++; if (sample_out !== exp) begin n_bad++; $display("FAIL pattern%0d_model: got %h want %h", i, sample_out, exp); end
            n_cmp++; if (sample_out !== r_tab[i]) begin n_bad++; $display("FAIL pattern%0d_const: got %h want %h", i, sample_out, r_tab[i]); end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_overrun();
        int lat;
        int extra;
        logic [15:0] exp;
        // Second strobe 5 clocks into the multiply is dropped
        send(16'h1000, 24'h800000);
        repeat (4) @(negedge clk);
        pulse_drop(16'h7FFF, 24'hFFFFFF);
        wait_valid(lat);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++; if (sample_out !== exp) begin n_bad++; $display("FAIL overrun_first_operands: got %h want %h", sample_out, exp); end
        n_cmp++; if (overrun_cnt !== 8'd1) begin n_bad++; $display("FAIL overrun_count1: got %0d want 1", overrun_cnt); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (out_valid) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL overrun_single_result: got %0d extra results want 0", extra); end
        // Strobe coinciding with the DONE edge is dropped, not queued
        send(16'hF000, 24'h800000);
        repeat (24) @(negedge clk);
        low_strobe = 1'b1;
        sample_in = 16'h7FFF;
        env_in = 24'hFFFFFF;
        @(negedge clk);
        low_strobe = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL done_edge_valid: got %b want 1", out_valid); end
        n_cmp++; if (sample_out !== exp) begin n_bad++; $display("FAIL done_edge_value: got %h want %h", sample_out, exp); end
        n_cmp++; if (overrun_cnt !== 8'd2) begin n_bad++; $display("FAIL done_edge_count: got %0d want 2", overrun_cnt); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (out_valid) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL done_edge_not_queued: got %0d extra results want 0", extra); end
        // Strobe held high: hundreds of drops, counter saturates
        low_strobe = 1'b1;
        sample_in = 16'h0100;
        env_in = 24'h100000;
        repeat (400) @(negedge clk);
        low_strobe = 1'b0;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_idle: got busy %b want 0", busy); end
        n_cmp++; if (overrun_cnt !== 8'hFF) begin n_bad++; $display("FAIL overrun_saturate: got %h want ff", overrun_cnt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int extra;
        logic [15:0] exp;
        do_reset();
        send(16'h4000, 24'h800000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_async: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        extra = 0;
        repeat (40) begin @(negedge clk); if (out_valid) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL rstmid_no_valid: got %0d results want 0", extra); end
        n_cmp++; if (sample_out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_sample_out: got %h want 0000", sample_out); end
        n_cmp++; if (overrun_cnt !== 8'h00) begin n_bad++; $display("FAIL rstmid_overrun: got %h want 00", overrun_cnt); end
        send(16'h4000, 24'h800000);
        wait_valid(lat);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++; if (lat != EW + 1) begin n_bad++; $display("FAIL rstmid_latency: got %0d want %0d", lat, EW + 1); end
        n_cmp++; if (sample_out !== exp) begin n_bad++; $display("FAIL rstmid_after: got %h want %h", sample_out, exp); end
        n_cmp++; if (sample_out !== 16'h2000) begin n_bad++; $display("FAIL rstmid_after_const: got %h want 2000", sample_out); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_smooth();
        int lat;
        logic [15:0] exp;
        logic [15:0] prev;
        do_reset();
        prev = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            send(16'h4000, 24'hFFFFFF);
            wait_valid(lat);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_cmp++; if (sample_out !== exp) begin n_bad++; $display("FAIL smooth%0d_model: got %h want %h", i, sample_out, exp); end
            if (i == 0) begin
                n_cmp++; if (sample_out !== 16'h0400) begin n_bad++; $display("FAIL smooth_first: got %h want 0400", sample_out); end
            end
            n_cmp++; if (!($signed(sample_out) >= $signed(prev) && $signed(sample_out) <= 16'sh4000)) begin
                n_bad++; $display("FAIL smooth%0d_monotonic: got %h want >= %h and <= 4000", i, sample_out, prev);
            end
            prev = sample_out;
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
`ifdef VCA_SMOOTH_EN
        test_smooth();
`else
        test_basic();
        test_patterns();
        test_overrun();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
